numarator_ceas_12h: RTL and testbench
=====================================

Name: numarator_ceas_12h

Overview:
BCD time-of-day counter for the digital clock in 12-hour format with an AM/PM flag. It divides the system clock to a 1 Hz tick and advances seconds, minutes, hours and AM/PM. Manual set inputs adjust minutes and hours. Its packed 25-bit time word feeds the digit-select multiplexer directly downstream, which routes one 4-bit field at a time to the BCD-to-7-segment decoder.

Parameters:
DIV_1HZ, 100000000, system clock cycles per 1 s tick; must be at least 2. Benches override it to 4.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst_n  in  1  asynchronous active-low reset.
en  in  1  run enable; 0 freezes the prescaler and the time.
set_mode  in  1  1 = manual set mode.
inc_min  in  1  increment-minutes strobe; one cycle per press, debounced upstream.
inc_hour  in  1  increment-hours strobe; one cycle per press, debounced upstream.
data_out  out  25  packed time word:
- [24] AM/PM (0 = AM, 1 = PM)
- [23:20] hour tens, [19:16] hour units
- [15:12] min tens, [11:8] min units
- [7:4] sec tens, [3:0] sec units
tick_1hz  out  1  one-cycle strobe, high in the cycle in which data_out first shows a newly advanced second.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - time = 12:00:00 AM, so data_out = 25'h0120000.
  - prescaler = 0, tick_1hz = 0.
- Prescaler: counter presc of width $clog2(DIV_1HZ), counting 0..DIV_1HZ-1.
  - adv = en & ~set_mode & (presc == DIV_1HZ-1).
  - On an adv edge: presc goes to 0 and time advances by 1 s.
- en = 0 with set_mode = 0: presc and time hold; tick_1hz = 0.
- Run advance, one BCD chain evaluated in a single edge:
  - sec units 9 -> 0, carries into sec tens.
  - sec tens 5 -> 0 (59 -> 00), carries into minutes.
  - min 59 -> 00, carries into hours.
- Hour sequence: 12 -> 01 -> 02 ... -> 11 -> 12 -> 01.
  - Hour tens is only ever 0 or 1.
  - Hours 12 is encoded as tens = 1, units = 2.
- AM/PM flag toggles exactly on the 11:59:59 -> 12:00:00 transition.
  - 11:59:59 PM -> 12:00:00 AM.
  - 12:59:59 -> 01:00:00 does not toggle it.
- tick_1hz is registered: it equals adv delayed one cycle and coincides with the updated data_out.
- Set mode (set_mode = 1; takes priority over en):
  - presc is held at 0 and the seconds are held at 00 (cleared on the first edge with set_mode = 1).
  - tick_1hz = 0.
  - inc_min: minutes +1, 59 -> 00, no carry into hours.
  - inc_hour: hours +1 with the same 12 -> 01 wrap; 11 -> 12 toggles AM/PM, so all 24 hours are reachable.
  - inc_min and inc_hour in the same cycle both apply independently.
  - A strobe held high increments once per cycle.
- inc_min and inc_hour are ignored when set_mode = 0.
- Leaving set mode: counting resumes from presc = 0, so the first tick comes DIV_1HZ cycles after set_mode falls, provided en = 1.
- Legal values only: every BCD field stays within its range (sec/min tens 0..5, units 0..9). Illegal states are unreachable from reset and need no recovery.
- All outputs are driven straight from registers; there is no combinational path from any input to any output.
- Reset asserted mid-count or mid-set: immediate return to the reset state. Operation restarts on the first edge after rst_n rises.

Decomposition:
- Shared package ceas_pkg holds:
  - field LSB localparams: AMPM_BIT = 24, H_TENS = 20, H_UNITS = 16, M_TENS = 12, M_UNITS = 8, S_TENS = 4, S_UNITS = 0.
  - BCD limits: TENS_MAX = 5, UNITS_MAX = 9, HOUR_MIN = 1, HOUR_MAX = 12.
  - the reset constant TIME_RESET = 25'h0120000.
- One sub-module, divizor_1hz: the parameterised prescaler. Inputs clk, rst_n, run, clr; output adv. The BCD chain stays in the top module.

Test Plan:
- Reset then DIV_1HZ = 4, en = 1, run 16 cycles -> data_out = 25'h0120004; tick_1hz pulsed 4 times, spaced 4 cycles apart.
- Force via set mode to 11:59 AM, exit, run 60 ticks -> at tick 60 data_out = 25'h1120000 (12:00:00 PM), flag toggled.
- From 12:59:59 PM, one tick -> 25'h1010000 (01:00:00 PM), AM/PM unchanged.
- From 11:59:59 PM, one tick -> 25'h0120000 (midnight AM).
- set_mode = 1 at 03:27:41 AM -> seconds become 00 next edge. Then:
  - 33 inc_min pulses -> minutes 00 with hours still 03.
  - 8 inc_hour pulses -> hours 11 AM; a 9th pulse -> 12 PM.
  - A simultaneous inc_min + inc_hour pulse -> both fields increment once.
- en = 0 for 10 cycles mid-count -> data_out and presc frozen. Then assert rst_n = 0 asynchronously between edges -> data_out = 25'h0120000 immediately.

Source files
------------

// File: rtl/numarator_ceas_12h_pkg.sv
// Shared definitions for the 12-hour BCD clock: field positions, BCD limits,
// the packed time word layout and the BCD increment helpers.
package ceas_pkg;

    localparam int AMPM_BIT = 24;
    localparam int H_TENS   = 20;
    localparam int H_UNITS  = 16;
    localparam int M_TENS   = 12;
    localparam int M_UNITS  = 8;
    localparam int S_TENS   = 4;
    localparam int S_UNITS  = 0;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
    } bcd2_t;

    // Field order matches the 25-bit word seen by the digit-select mux.
    typedef struct packed {
        logic  pm;
        bcd2_t hour;
        bcd2_t min;
        bcd2_t sec;
    } time_t;

    localparam logic [3:0] TENS_MAX  = 4'd5;
    localparam logic [3:0] UNITS_MAX = 4'd9;
    localparam bcd2_t      HOUR_MIN  = 8'h01;
    localparam bcd2_t      HOUR_MAX  = 8'h12;
    localparam time_t      TIME_RESET = 25'h0120000;

    function automatic logic at_max(bcd2_t v);
        return (v.tens == TENS_MAX) && (v.units == UNITS_MAX);
    endfunction

    // Seconds/minutes: 59 wraps to 00.
    function automatic bcd2_t bcd_inc(bcd2_t v);
        bcd2_t r;
        r = v;
        if (v.units == UNITS_MAX) begin
            r.units = 4'd0;
            r.tens  = (v.tens == TENS_MAX) ? 4'd0 : v.tens + 4'd1;
        end else begin
            r.units = v.units + 4'd1;
        end
        return r;
    endfunction

    // Hours: 12 wraps to 01, 09 rolls to 10.
    function automatic bcd2_t hour_inc(bcd2_t h);
        bcd2_t r;
        r = h;
        if (h == HOUR_MAX) begin
            r = HOUR_MIN;
        end else if (h.units == UNITS_MAX) begin
            r.tens  = h.tens + 4'd1;
            r.units = 4'd0;
        end else begin
            r.units = h.units + 4'd1;
        end
        return r;
    endfunction

    function automatic logic hour_flips_ampm(bcd2_t h);
        return h == 8'h11;
    endfunction

endpackage

// File: rtl/numarator_ceas_12h_if.sv
// Control strobes in, packed time word and 1 Hz strobe out.
interface numarator_ceas_12h_if;
    logic        en;
    logic        set_mode;
    logic        inc_min;
    logic        inc_hour;
    logic [24:0] data_out;
    logic        tick_1hz;

    modport master (output en, set_mode, inc_min, inc_hour,
                    input  data_out, tick_1hz);
    modport slave  (input  en, set_mode, inc_min, inc_hour,
                    output data_out, tick_1hz);
endinterface

// File: rtl/numarator_ceas_12h_divizor_1hz.sv
// Prescaler: counts 0..DIV_1HZ-1 while run is high and flags the last count.
module divizor_1hz #(
    parameter int DIV_1HZ = 100000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic adv
);
    localparam int            PW   = $clog2(DIV_1HZ);
    localparam logic [PW-1:0] LAST = PW'(DIV_1HZ - 1);

    logic [PW-1:0] presc_q, presc_d;

    assign adv = run && (presc_q == LAST);

    always_comb begin
        presc_d = presc_q;
        if (clr || adv)
            presc_d = '0;
        else if (run)
            presc_d = presc_q + PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            presc_q <= '0;
        else
            presc_q <= presc_d;
    end
endmodule

// File: rtl/numarator_ceas_12h.sv
// 12-hour BCD time-of-day counter with AM/PM flag, 1 Hz run mode and manual set.
module numarator_ceas_12h
    import ceas_pkg::*;
#(
    parameter int DIV_1HZ = 100000000
) (
    input logic                  clk,
    input logic                  rst_n,
    numarator_ceas_12h_if.slave  bus
);
    time_t time_q, time_d;
    logic  tick_q, tick_d;
    logic  adv;

    divizor_1hz #(.DIV_1HZ(DIV_1HZ)) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (bus.en && !bus.set_mode),
        .clr   (bus.set_mode),
        .adv   (adv)
    );

    always_comb begin
        time_d = time_q;
        tick_d = adv;
        if (bus.set_mode) begin
            time_d.sec = '0;
            if (bus.inc_min)
                time_d.min = bcd_inc(time_q.min);
            if (bus.inc_hour) begin
                time_d.hour = hour_inc(time_q.hour);
                if (hour_flips_ampm(time_q.hour))
                    time_d.pm = ~time_q.pm;
            end
        end else if (adv) begin
            // Full carry chain resolved in one edge.
            time_d.sec = bcd_inc(time_q.sec);
            if (at_max(time_q.sec)) begin
                time_d.min = bcd_inc(time_q.min);
                if (at_max(time_q.min)) begin
                    time_d.hour = hour_inc(time_q.hour);
                    if (hour_flips_ampm(time_q.hour))
                        time_d.pm = ~time_q.pm;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            time_q <= TIME_RESET;
            tick_q <= 1'b0;
        end else begin
            time_q <= time_d;
            tick_q <= tick_d;
        end
    end

    assign bus.data_out = time_q;
    assign bus.tick_1hz = tick_q;
endmodule

// File: tb/tb_numarator_ceas_12h.sv
// Scoreboard bench for the 12-hour clock with a fast prescaler.
module tb_numarator_ceas_12h;
    import ceas_pkg::*;

    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    numarator_ceas_12h_if bus();

    numarator_ceas_12h #(.DIV_1HZ(DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [25:0] exp_q[$];
    logic [25:0] exp_v;

    int m_h, m_m, m_s, m_pm, m_p;

    function automatic logic [24:0] m_word();
        logic [24:0] w;
        w = '0;
        w[AMPM_BIT]    = m_pm[0];
        w[H_TENS +: 4]  = 4'(m_h / 10);
        w[H_UNITS +: 4] = 4'(m_h % 10);
        w[M_TENS +: 4]  = 4'(m_m / 10);
        w[M_UNITS +: 4] = 4'(m_m % 10);
        w[S_TENS +: 4]  = 4'(m_s / 10);
        w[S_UNITS +: 4] = 4'(m_s % 10);
        return w;
    endfunction

    task automatic m_reset();
        m_h = 12; m_m = 0; m_s = 0; m_pm = 0; m_p = 0;
    endtask

    task automatic m_hour_inc();
        if (m_h == 11) m_pm = 1 - m_pm;
        m_h = (m_h == 12) ? 1 : m_h + 1;
    endtask

    // Model one rising edge from the current inputs, queue the expectation, then step the DUT.
    task automatic clk_step();
        logic tk;
        tk = 1'b0;
        if (!rst_n) begin
            m_reset();
        end else if (bus.set_mode) begin
            m_p = 0;
            m_s = 0;
            if (bus.inc_min) m_m = (m_m + 1) % 60;
            if (bus.inc_hour) m_hour_inc();
        end else if (bus.en) begin
            if (m_p == DIV - 1) begin
                m_p = 0;
                tk = 1'b1;
                m_s = m_s + 1;
                if (m_s == 60) begin
                    m_s = 0;
                    m_m = m_m + 1;
                    if (m_m == 60) begin
                        m_m = 0;
                        m_hour_inc();
                    end
                end
            end else begin
                m_p = m_p + 1;
            end
        end
        exp_q.push_back({tk, m_word()});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.en = 1'b0; bus.set_mode = 1'b0; bus.inc_min = 1'b0; bus.inc_hour = 1'b0;
        rst_n = 1'b0;
        m_reset();
        for (int i = 0; i < 3; i++) begin
            clk_step();
            exp_v = exp_q.pop_front();
            n_vec++;
            if ({bus.tick_1hz, bus.data_out} !== exp_v) begin
                n_err++;
                $display("FAIL reset_hold: got tick=%b time=%h, expected tick=%b time=%h",
                         bus.tick_1hz, bus.data_out, exp_v[25], exp_v[24:0]);
            end
        end
        n_vec++;
        if (bus.data_out !== 25'h0120000 || bus.tick_1hz !== 1'b0) begin
            n_err++;
            $display("FAIL reset_value: got tick=%b time=%h, expected tick=0 time=0120000",
                     bus.tick_1hz, bus.data_out);
        end
        #2 rst_n = 1'b1;
    endtask

    task automatic test_count();
        int ticks, last;
        ticks = 0; last = -1;
        bus.en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            clk_step();
            exp_v = exp_q.pop_front();
            n_vec++;
            if ({bus.tick_1hz, bus.data_out} !== exp_v) begin
                n_err++;
                $display("FAIL count_cycle%0d: got tick=%b time=%h, expected tick=%b time=%h",
                         i, bus.tick_1hz, bus.data_out, exp_v[25], exp_v[24:0]);
            end
            if (bus.tick_1hz === 1'b1) begin
                if (last >= 0) begin
                    n_vec++;
                    if (i - last != DIV) begin
                        n_err++;
                        $display("FAIL count_spacing: got %0d cycles, expected %0d", i - last, DIV);
                    end
                end
                last = i;
                ticks++;
            end
        end
        n_vec++;
        if (bus.data_out !== 25'h0120004 || ticks != 4) begin
            n_err++;
            $display("FAIL count_16: got time=%h ticks=%0d, expected time=0120004 ticks=4",
                     bus.data_out, ticks);
        end
    endtask

    // Drive n cycles with the current inputs, checking every cycle against the model.
    task automatic run_phase(input int n, input bit im, input bit ih, input bit sm);
        bus.set_mode = sm; bus.inc_min = im; bus.inc_hour = ih; bus.en = 1'b1;
        for (int i = 0; i < n; i++) begin
            clk_step();
            exp_v = exp_q.pop_front();
            n_vec++;
            if ({bus.tick_1hz, bus.data_out} !== exp_v) begin
                n_err++;
                $display("FAIL phase_cycle%0d: got tick=%b time=%h, expected tick=%b time=%h",
                         i, bus.tick_1hz, bus.data_out, exp_v[25], exp_v[24:0]);
            end
        end
        bus.inc_min = 1'b0; bus.inc_hour = 1'b0;
    endtask

    task automatic test_noon();
        run_phase(11, 1'b0, 1'b1, 1'b1);
        run_phase(59, 1'b1, 1'b0, 1'b1);
        run_phase(60 * DIV, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (bus.data_out !== 25'h1120000 || bus.tick_1hz !== 1'b1) begin
            n_err++;
            $display("FAIL noon: got tick=%b time=%h, expected tick=1 time=1120000",
                     bus.tick_1hz, bus.data_out);
        end
    endtask

    task automatic test_one_pm();
        run_phase(59, 1'b1, 1'b0, 1'b1);
        run_phase(59 * DIV, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (bus.data_out !== 25'h1125959) begin
            n_err++;
            $display("FAIL pre_one_pm: got time=%h, expected 1125959", bus.data_out);
        end
        run_phase(DIV, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (bus.data_out !== 25'h1010000) begin
            n_err++;
            $display("FAIL one_pm: got time=%h, expected 1010000", bus.data_out);
        end
    endtask

    task automatic test_midnight();
        run_phase(10, 1'b0, 1'b1, 1'b1);
        run_phase(59, 1'b1, 1'b0, 1'b1);
        run_phase(60 * DIV, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (bus.data_out !== 25'h0120000 || bus.tick_1hz !== 1'b1) begin
            n_err++;
            $display("FAIL midnight: got tick=%b time=%h, expected tick=1 time=0120000",
                     bus.tick_1hz, bus.data_out);
        end
    endtask

    task automatic test_set();
        run_phase(3, 1'b0, 1'b1, 1'b1);
        run_phase(27, 1'b1, 1'b0, 1'b1);
        run_phase(41 * DIV, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (bus.data_out !== 25'h0032741) begin
            n_err++;
            $display("FAIL set_start: got time=%h, expected 0032741", bus.data_out);
        end
        run_phase(1, 1'b0, 1'b0, 1'b1);
        n_vec++;
        if (bus.data_out !== 25'h0032700) begin
            n_err++;
            $display("FAIL set_sec_clear: got time=%h, expected 0032700", bus.data_out);
        end
        run_phase(33, 1'b1, 1'b0, 1'b1);
        n_vec++;
        if (bus.data_out !== 25'h0030000) begin
            n_err++;
            $display("FAIL set_min_wrap: got time=%h, expected 0030000", bus.data_out);
        end
        run_phase(8, 1'b0, 1'b1, 1'b1);
        n_vec++;
        if (bus.data_out !== 25'h0110000) begin
            n_err++;
            $display("FAIL set_hour_11: got time=%h, expected 0110000", bus.data_out);
        end
        run_phase(1, 1'b0, 1'b1, 1'b1);
        n_vec++;
        if (bus.data_out !== 25'h1120000) begin
            n_err++;
            $display("FAIL set_hour_12pm: got time=%h, expected 1120000", bus.data_out);
        end
        run_phase(1, 1'b1, 1'b1, 1'b1);
        n_vec++;
        if (bus.data_out !== 25'h1010100) begin
            n_err++;
            $display("FAIL set_both: got time=%h, expected 1010100", bus.data_out);
        end
        // Strobes outside set mode must be ignored.
        run_phase(2 * DIV + 1, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_freeze_reset();
        logic [24:0] frozen;
        run_phase(6, 1'b0, 1'b0, 1'b0);
        frozen = m_word();
        bus.en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            clk_step();
            exp_v = exp_q.pop_front();
            n_vec++;
            if ({bus.tick_1hz, bus.data_out} !== {1'b0, frozen} || exp_v !== {1'b0, frozen}) begin
                n_err++;
                $display("FAIL freeze_cycle%0d: got tick=%b time=%h, expected tick=0 time=%h",
                         i, bus.tick_1hz, bus.data_out, frozen);
            end
        end
        run_phase(5, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus.data_out !== 25'h0120000 || bus.tick_1hz !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: got tick=%b time=%h, expected tick=0 time=0120000",
                     bus.tick_1hz, bus.data_out);
        end
        clk_step();
        exp_v = exp_q.pop_front();
        n_vec++;
        if ({bus.tick_1hz, bus.data_out} !== exp_v) begin
            n_err++;
            $display("FAIL reset_held: got tick=%b time=%h, expected tick=%b time=%h",
                     bus.tick_1hz, bus.data_out, exp_v[25], exp_v[24:0]);
        end
        rst_n = 1'b1;
        run_phase(2 * DIV, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (bus.data_out !== 25'h0120002) begin
            n_err++;
            $display("FAIL restart: got time=%h, expected 0120002", bus.data_out);
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_noon();
        test_one_pm();
        test_midnight();
        test_set();
        test_freeze_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
